// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the HI/LO multiply/divide sequencer
package mips_pkg;

    localparam int MULDIV_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

endpackage

// File: rtl/mips_muldiv_step.sv
// rtl/mips_muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module mips_muldiv_step #(
    parameter int W = 32
) (
    input  logic           i_is_div,
    input  logic [2*W-1:0] i_acc,
    input  logic [2*W-1:0] i_mcand,
    input  logic [W-1:0]   i_mplier,
    output logic [2*W-1:0] o_acc,
    output logic [2*W-1:0] o_mcand,
    output logic [W-1:0]   o_mplier
);

    // Divide keeps remainder:quotient in acc; the top W+1 bits are the shifted remainder.
    logic [W:0] w_trial;
    assign w_trial = i_acc[2*W-1:W-1] - {1'b0, i_mcand[W-1:0]};

    always_comb begin
        o_acc    = i_acc;
        o_mcand  = i_mcand;
        o_mplier = i_mplier;
        if (i_is_div) begin
            if (!w_trial[W]) begin
                o_acc = {w_trial[W-1:0], i_acc[W-2:0], 1'b1};
            end else begin
                o_acc = {i_acc[2*W-2:0], 1'b0};
            end
        end else begin
            if (i_mplier[0]) begin
                o_acc = i_acc + i_mcand;
            end
            o_mcand  = {i_mcand[2*W-2:0], 1'b0};
            o_mplier = {1'b0, i_mplier[W-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_seq.sv
// rtl/mips_muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer driving HI/LO
// Optional build macro MIPS_MULDIV_EARLY_TERM_EN: multiplies stop once the multiplier is exhausted.
module mips_muldiv_seq
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = MULDIV_DATA_WIDTH,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  hi_write,
    output logic                  lo_write,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  div_zero
);

    localparam int W = DATA_WIDTH;

    muldiv_state_e   r_state;
    muldiv_op_e      r_op;
    logic [W-1:0]    r_rs;
    logic [W-1:0]    r_rt;
    logic [2*W-1:0]  r_acc;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mplier;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_zero;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_div_zero;

    logic            w_is_div;
    logic            w_signed;
    logic            w_rs_neg;
    logic            w_rt_neg;
    logic [W-1:0]    w_rs_abs;
    logic [W-1:0]    w_rt_abs;
    logic [2*W-1:0]  w_acc_nxt;
    logic [2*W-1:0]  w_mcand_nxt;
    logic [W-1:0]    w_mplier_nxt;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;
    logic            w_last;
    logic            w_run_exit;

    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_rs_neg = w_signed & r_rs[W-1];
    assign w_rt_neg = w_signed & r_rt[W-1];
    assign w_rs_abs = w_rs_neg ? (~r_rs + 1'b1) : r_rs;
    assign w_rt_abs = w_rt_neg ? (~r_rt + 1'b1) : r_rt;

    mips_muldiv_step #(.W(W)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_nxt),
        .o_mcand  (w_mcand_nxt),
        .o_mplier (w_mplier_nxt)
    );

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
    assign w_last = (r_cnt == CNT_WIDTH'(W - 1));

`ifdef MIPS_MULDIV_EARLY_TERM_EN
    assign w_run_exit = w_last | (~w_is_div & (w_mplier_nxt == '0));
`else
    assign w_run_exit = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_MULT;
            r_rs       <= '0;
            r_rt       <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_op       <= muldiv_op_e'(op);
                        r_rs       <= rs_val;
                        r_rt       <= rt_val;
                        r_div_zero <= 1'b0;
                        r_state    <= ST_PREP;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_cnt    <= '0;
                        r_mplier <= w_rt_abs;
                        // Divide-by-zero skips RUN; FIX loads the fixed hi/lo pattern.
                        if (w_is_div && (r_rt == '0)) begin
                            r_div_zero <= 1'b1;
                            r_zero     <= 1'b1;
                            r_state    <= ST_FIX;
                        end else begin
                            r_zero  <= 1'b0;
                            r_state <= ST_RUN;
                            if (w_is_div) begin
                                r_acc   <= {{W{1'b0}}, w_rs_abs};
                                r_mcand <= {{W{1'b0}}, w_rt_abs};
                            end else begin
                                r_acc   <= '0;
                                r_mcand <= {{W{1'b0}}, w_rs_abs};
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= w_mcand_nxt;
                        r_mplier <= w_mplier_nxt;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_run_exit) begin
                            r_state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_zero) begin
                            r_hi <= r_rs;
                            r_lo <= '1;
                        end else if (w_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*W-1:W];
                            r_lo <= w_prod[W-1:0];
                        end
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == ST_PREP) || (r_state == ST_RUN) || (r_state == ST_FIX);
    assign done     = (r_state == ST_DONE);
    assign hi_write = done;
    assign lo_write = done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule
